// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider, one quotient bit per
// clock. Unsigned WIDTH_N-bit dividend by WIDTH_D-bit divisor, start/done
// handshake, divide-by-zero flag.
// Optional build macro SEQ_DIVIDER_SELFCHECK_EN adds a q*y+r==x check on
// every completed operation and a sticky chk_err output.
module seq_divider #(
   parameter int WIDTH_N = 8,
   parameter int WIDTH_D = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH_N-1:0] x,
   input  logic [WIDTH_D-1:0] y,
   output logic               busy,
   output logic               done,
   output logic [WIDTH_N-1:0] q,
   output logic [WIDTH_D-1:0] r,
`ifdef SEQ_DIVIDER_SELFCHECK_EN
   output logic               dz,
   output logic               chk_err
`else
   output logic               dz
`endif
);

   localparam int CW = (WIDTH_N > 2) ? $clog2(WIDTH_N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state;
   logic [WIDTH_D-1:0] y_reg;     // captured divisor
   logic [WIDTH_D-1:0] pr;        // partial remainder, always < y_reg
   logic [WIDTH_N-1:0] sn;        // dividend bits still to be shifted in
   logic [WIDTH_N-1:0] qs;        // quotient under construction
   logic [CW-1:0]      count;     // iteration index 0..WIDTH_N-1
   logic               dz_pend;   // current operation has a zero divisor
   logic [WIDTH_D:0]   t;         // trial value {pr, next dividend bit}
   logic [WIDTH_D:0]   diff;      // t - y in WIDTH_D+1 bits
   logic               take;      // t >= y: subtract and emit a 1

   // Trial subtraction. Because pr < y, t <= 2y-1, so a non-negative
   // difference always fits in WIDTH_D bits and the top bit of diff is
   // exactly the borrow: it doubles as the t>=y comparator.
   always_comb begin
      t    = {pr, sn[WIDTH_N-1]};
      diff = t - {1'b0, y_reg};
      take = ~diff[WIDTH_D];
   end

`ifdef SEQ_DIVIDER_SELFCHECK_EN
   logic [WIDTH_N-1:0]         x_reg;
   logic [WIDTH_N+WIDTH_D-1:0] recon;
   logic                       mismatch;

   // Reconstruct the dividend from the finished quotient and remainder.
   always_comb begin
      recon    = (WIDTH_N+WIDTH_D)'(qs) * (WIDTH_N+WIDTH_D)'(y_reg)
               + (WIDTH_N+WIDTH_D)'(pr);
      mismatch = (recon != (WIDTH_N+WIDTH_D)'(x_reg));
   end
`endif

   // Control FSM and datapath; all outputs are registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         y_reg   <= '0;
         pr      <= '0;
         sn      <= '0;
         qs      <= '0;
         count   <= '0;
         dz_pend <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         q       <= '0;
         r       <= '0;
         dz      <= 1'b0;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
         x_reg   <= '0;
         chk_err <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  y_reg   <= y;
                  sn      <= x;
                  count   <= '0;
                  busy    <= 1'b1;
                  dz_pend <= (y == '0);
`ifdef SEQ_DIVIDER_SELFCHECK_EN
                  x_reg   <= x;
`endif
                  if (y == '0) begin
                     // Zero divisor: preload the fixed result and skip RUN.
                     pr    <= x[WIDTH_D-1:0];
                     qs    <= '1;
                     state <= FIN;
                  end else begin
                     pr    <= '0;
                     qs    <= '0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               sn    <= sn << 1;
               qs    <= {qs[WIDTH_N-2:0], take};
               pr    <= take ? diff[WIDTH_D-1:0] : t[WIDTH_D-1:0];
               count <= count + 1'b1;
               if (count == CW'(WIDTH_N-1))
                  state <= FIN;
            end
            FIN: begin
               q     <= qs;
               r     <= pr;
               dz    <= dz_pend;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
               if (mismatch && !dz_pend)
                  chk_err <= 1'b1;
`endif
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed operations with literal expectations
// plus a cycle-level reference model built from x/y and x%y, checked on
// every negative clock edge.
module tb_seq_divider;

   localparam int N = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] x;
   logic [D-1:0] y;
   logic         busy;
   logic         done;
   logic [N-1:0] q;
   logic [D-1:0] r;
   logic         dz;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
   logic         chk_err;
`endif

   int checks = 0;
   int errors = 0;

   seq_divider #(.WIDTH_N(N), .WIDTH_D(D)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .x(x),
      .y(y),
      .busy(busy),
      .done(done),
      .q(q),
      .r(r),
`ifdef SEQ_DIVIDER_SELFCHECK_EN
      .dz(dz),
      .chk_err(chk_err)
`else
      .dz(dz)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted operation keeps busy high for N+1 cycles
   // (1 for a zero divisor), then done pulses with the arithmetic result.
   int           m_cnt;
   logic         m_done;
   logic [N-1:0] m_pq, m_lq;
   logic [D-1:0] m_pr, m_lr;
   logic         m_pdz, m_ldz;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt  <= 0;
         m_done <= 1'b0;
         m_lq   <= '0;
         m_lr   <= '0;
         m_ldz  <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_done <= 1'b1;
               m_lq   <= m_pq;
               m_lr   <= m_pr;
               m_ldz  <= m_pdz;
            end
         end else if (start) begin
            if (y == 0) begin
               m_pq  <= '1;
               m_pr  <= x[D-1:0];
               m_pdz <= 1'b1;
               m_cnt <= 1;
            end else begin
               m_pq  <= N'(int'(x) / int'(y));
               m_pr  <= D'(int'(x) % int'(y));
               m_pdz <= 1'b0;
               m_cnt <= N + 1;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         chk("busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
         chk("done", {31'd0, done}, {31'd0, m_done});
         if (m_done || m_cnt == 0) begin
            chk("q", {24'd0, q}, {24'd0, m_lq});
            chk("r", {28'd0, r}, {28'd0, m_lr});
            chk("dz", {31'd0, dz}, {31'd0, m_ldz});
         end
`ifdef SEQ_DIVIDER_SELFCHECK_EN
         chk("chk_err", {31'd0, chk_err}, 32'd0);
`endif
      end
   end

   // Issue one operation in the next cycle, wait for done, optionally check
   // literal results and the latency (edges from accept to done visible).
   task automatic run_op(input logic [N-1:0] a, input logic [D-1:0] b, input bit lit,
                         input logic [N-1:0] eq, input logic [D-1:0] er, input logic edz);
      int n;
      @(negedge clk);
      x = a;
      y = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
      if (lit) begin
         $display("op x=%0d y=%0d -> q=%0d r=%0d dz=%0d latency=%0d", a, b, q, r, dz, n);
         chk("lit_q", {24'd0, q}, {24'd0, eq});
         chk("lit_r", {28'd0, r}, {28'd0, er});
         chk("lit_dz", {31'd0, dz}, {31'd0, edz});
         chk("lit_latency", n, (b == 0) ? 1 : N + 1);
      end
   endtask

   int dones;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      x = '0;
      y = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_q", {24'd0, q}, 32'd0);
      chk("rst_r", {28'd0, r}, 32'd0);
      chk("rst_dz", {31'd0, dz}, 32'd0);
      #3 rst = 1'b0;

      run_op(8'd200, 4'd7, 1'b1, 8'd28, 4'd4, 1'b0);
      run_op(8'd255, 4'd15, 1'b1, 8'd17, 4'd0, 1'b0);
      run_op(8'd5, 4'd9, 1'b1, 8'd0, 4'd5, 1'b0);
      run_op(8'd15, 4'd0, 1'b1, 8'd255, 4'd15, 1'b1);
      run_op(8'd16, 4'd4, 1'b1, 8'd4, 4'd0, 1'b0);

      // Start while busy must be ignored: one done, first operand's result.
      @(negedge clk);
      x = 8'd200; y = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      x = 8'd100; y = 4'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            dones++;
            chk("busy_start_q", {24'd0, q}, 32'd28);
            chk("busy_start_r", {28'd0, r}, 32'd4);
         end
         @(negedge clk);
      end
      $display("op ignored-start test: done pulses=%0d", dones);
      chk("busy_start_dones", dones, 1);

      // Abort mid-operation with an asynchronous reset.
      @(negedge clk);
      x = 8'd200; y = 4'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_q", {24'd0, q}, 32'd0);
      chk("abort_r", {28'd0, r}, 32'd0);
      chk("abort_dz", {31'd0, dz}, 32'd0);
      @(negedge clk);
      #3 rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dones++;
      end
      $display("op abort test: done pulses after reset=%0d", dones);
      chk("abort_no_done", dones, 0);
      run_op(8'd9, 4'd2, 1'b1, 8'd4, 4'd1, 1'b0);

      // Full sweep of nonzero divisors; the model checks every result.
      for (int b = 1; b < 16; b++) begin
         for (int a = 0; a < 256; a++) begin
            run_op(N'((a * 37 + b * 11) % 256), D'(b), 1'b0, '0, '0, 1'b0);
         end
      end
      $display("op sweep complete: 3840 operations");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
